// File: rtl/bn_batch_loader_if.sv
// Sample-stream and forward-stage bundle for the batch-norm batch loader.
// The loader uses the slave modport. The producer and forward-stage side uses the master modport.
interface bn_batch_loader_if #(
  parameter int IL   = 8,
  parameter int FL   = 12,
  parameter int size = 16
);
  localparam int DW = IL + FL;

  logic                   in_valid;
  logic signed [DW-1:0]   in_data;
  logic                   in_last;
  logic                   in_ready;
  logic signed [DW-1:0]   gamma_in;
  logic signed [DW-1:0]   beta_in;
  logic [size-1:0][DW-1:0] batch_out;
  logic [4:0]             num_out;
  logic signed [DW-1:0]   gamma_out;
  logic signed [DW-1:0]   beta_out;
  logic                   input_ready;
  logic [1:0]             fwd_state;

  modport master (
    output in_valid, in_data, in_last, gamma_in, beta_in, fwd_state,
    input  in_ready, batch_out, num_out, gamma_out, beta_out, input_ready
  );

  modport slave (
    input  in_valid, in_data, in_last, gamma_in, beta_in, fwd_state,
    output in_ready, batch_out, num_out, gamma_out, beta_out, input_ready
  );
endinterface

// File: rtl/bn_batch_loader.sv
// Collects a streamed batch of fixed-point samples, launches the forward stage,
// and holds the operands stable until that stage reports it is idle again.
module bn_batch_loader #(
  parameter int IL    = 8,
  parameter int FL    = 12,
  parameter int size  = 16,
  parameter int width = $clog2(size)
) (
  input  logic             clk,
  input  logic             reset,
  bn_batch_loader_if.slave bif,
  output logic             busy,
  output logic [15:0]      batch_cnt
);
  localparam int DW = IL + FL;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [width:0]       count_q, count_d, count_inc;
  logic signed [DW-1:0] batch_q [size];
  logic signed [DW-1:0] batch_d [size];
  logic [4:0]           num_q, num_d;
  logic signed [DW-1:0] gamma_q, gamma_d;
  logic signed [DW-1:0] beta_q, beta_d;
  logic [15:0]          bcnt_q, bcnt_d;
  logic                 accept;
  logic                 clear;

  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    num_d   = num_q;
    gamma_d = gamma_q;
    beta_d  = beta_q;
    bcnt_d  = bcnt_q;
    accept  = 1'b0;
    clear   = 1'b0;
    case (state_q)
      FILL: begin
        if (bif.in_valid) begin
          accept  = 1'b1;
          count_d = count_inc;
          if (count_q == '0) begin
            gamma_d = bif.gamma_in;
            beta_d  = bif.beta_in;
          end
          // Auto-close at capacity so a (size+1)th sample is never accepted.
          if (bif.in_last || count_inc == (width+1)'(size)) begin
            num_d   = 5'(count_inc);
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        if (bif.fwd_state == 2'b01) state_d = WAIT;
      end
      WAIT: begin
        // Both 10->00 and a direct 01->00 mark completion of the forward pass.
        if (bif.fwd_state == 2'b00) begin
          state_d = FILL;
          count_d = '0;
          clear   = 1'b1;
          bcnt_d  = bcnt_q + 16'd1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  for (genvar gi = 0; gi < size; gi++) begin : g_entry
    localparam logic [width:0] IDX = (width+1)'(gi);
    assign batch_d[gi] = clear ? '0
                       : ((accept && count_q == IDX) ? bif.in_data : batch_q[gi]);
    assign bif.batch_out[gi] = batch_q[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      count_q <= '0;
      num_q   <= '0;
      gamma_q <= '0;
      beta_q  <= '0;
      bcnt_q  <= '0;
      for (int i = 0; i < size; i++) batch_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      num_q   <= num_d;
      gamma_q <= gamma_d;
      beta_q  <= beta_d;
      bcnt_q  <= bcnt_d;
      batch_q <= batch_d;
    end
  end

  assign bif.in_ready    = (state_q == FILL);
  assign bif.input_ready = (state_q == LAUNCH);
  assign bif.num_out     = num_q;
  assign bif.gamma_out   = gamma_q;
  assign bif.beta_out    = beta_q;
  assign busy            = (state_q != FILL);
  assign batch_cnt       = bcnt_q;
endmodule
